// File: rtl/cordic_pkg.sv
// Shared CORDIC constants, atan table and state/mode encodings.
// Pure package: no latency, no handshakes.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } mode_e;

  localparam int Q30_FB = 30;
  localparam logic signed [31:0] PI_OVER_2_Q30 = 32'sd1686629713;

  // Round-half-up from Q30 down to fb fractional bits (1 <= fb <= 30)
  function automatic logic signed [31:0] rescale_q30(input logic signed [31:0] v, input int fb);
    if (fb >= Q30_FB) return v;
    return (v + (32'sd1 <<< (Q30_FB - fb - 1))) >>> (Q30_FB - fb);
  endfunction

  function automatic logic signed [31:0] atan_lut(input int i, input int fb);
    logic signed [31:0] q30;
    case (i)
      0:       q30 = 32'sd843314857;
      1:       q30 = 32'sd497837830;
      2:       q30 = 32'sd263043837;
      3:       q30 = 32'sd133525159;
      4:       q30 = 32'sd67021693;
      5:       q30 = 32'sd33543516;
      6:       q30 = 32'sd16775851;
      7:       q30 = 32'sd8388437;
      8:       q30 = 32'sd4194283;
      9:       q30 = 32'sd2097149;
      // beyond here atan(2^-i) equals 2^-i to within one Q30 LSB
      default: q30 = (i <= Q30_FB) ? (32'sd1 <<< (Q30_FB - i)) : 32'sd0;
    endcase
    return rescale_q30(q30, fb);
  endfunction

  function automatic int pi_over_2(input int fb);
    return int'(rescale_q30(PI_OVER_2_Q30, fb));
  endfunction

  function automatic int half(input int fb);
    return 1 << (fb - 1);
  endfunction

  function automatic int inv_gain(input int n, input int fb);
    real k;
    real p;
    k = 1.0;
    p = 1.0;
    for (int i = 0; i < n; i++) begin
      k = k / $sqrt(1.0 + p);
      p = p * 0.25;
    end
    return $rtoi(k * (2.0 ** fb) + 0.5);
  endfunction

endpackage

// File: rtl/cordic_microrot.sv
// One combinational CORDIC micro-rotation step (zero latency).
// No handshakes; the engine sequences it once per cycle.
module cordic_microrot
  import cordic_pkg::*;
#(
  parameter int WORD_LENGTH = 21,
  parameter int ITER_W      = 5
) (
  input  logic signed [WORD_LENGTH-1:0] x,
  input  logic signed [WORD_LENGTH-1:0] y,
  input  logic signed [WORD_LENGTH-1:0] z,
  input  logic signed [WORD_LENGTH-1:0] alpha,
  input  logic        [ITER_W-1:0]      i,
  input  mode_e                         mode,
  output logic signed [WORD_LENGTH-1:0] x_nxt,
  output logic signed [WORD_LENGTH-1:0] y_nxt,
  output logic signed [WORD_LENGTH-1:0] z_nxt
);

  logic                          d_pos;
  logic signed [WORD_LENGTH-1:0] x_sh;
  logic signed [WORD_LENGTH-1:0] y_sh;

  always_comb begin
    // rotation drives z toward 0, vectoring drives y toward 0
    d_pos = (mode == MODE_ROT) ? ~z[WORD_LENGTH-1] : y[WORD_LENGTH-1];
    x_sh  = x >>> i;
    y_sh  = y >>> i;
    x_nxt = d_pos ? (x - y_sh)    : (x + y_sh);
    y_nxt = d_pos ? (y + x_sh)    : (y - x_sh);
    z_nxt = d_pos ? (z - alpha)   : (z + alpha);
  end

endmodule

// File: rtl/cordic_engine.sv
// Folded CORDIC: rotation (cos/sin) or vectoring (magnitude/atan) through one micro-rotation stage.
// out_valid N_ITERATIONS edges after accept; in_ready low while busy or holding; result held until out_ready.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int WORD_LENGTH  = 21,
  parameter int FRAC_BITS    = 19,
  parameter int N_ITERATIONS = 17,
  parameter int ITER_W       = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          mode,
  input  logic signed [WORD_LENGTH-1:0] x_in,
  input  logic signed [WORD_LENGTH-1:0] y_in,
  input  logic signed [WORD_LENGTH-1:0] z_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [WORD_LENGTH-1:0] x_out,
  output logic signed [WORD_LENGTH-1:0] y_out,
  output logic signed [WORD_LENGTH-1:0] z_out,
  output logic                          err
);

  localparam logic signed [WORD_LENGTH-1:0] INV_GAIN  = WORD_LENGTH'(inv_gain(N_ITERATIONS, FRAC_BITS));
  localparam logic signed [WORD_LENGTH-1:0] PI_OVER_2 = WORD_LENGTH'(pi_over_2(FRAC_BITS));
  localparam logic signed [WORD_LENGTH-1:0] HALF      = WORD_LENGTH'(half(FRAC_BITS));
  localparam logic        [ITER_W-1:0]      LAST_ITER = ITER_W'(N_ITERATIONS - 1);

  typedef struct packed {
    logic signed [WORD_LENGTH-1:0] x;
    logic signed [WORD_LENGTH-1:0] y;
    logic signed [WORD_LENGTH-1:0] z;
  } vec_t;

  state_e              state_q, state_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  mode_e               mode_q, mode_d;
  logic                err_q, err_d;
  vec_t                vec_q, vec_d;
  vec_t                res_q, res_d;
  vec_t                vec_nxt;
  logic signed [WORD_LENGTH-1:0] alpha;
  logic                rot_err;
  logic                vec_err;

  always_comb begin
    alpha   = WORD_LENGTH'(atan_lut(int'(iter_q), FRAC_BITS));
    rot_err = (z_in > PI_OVER_2) || (z_in < -PI_OVER_2);
    vec_err = x_in[WORD_LENGTH-1] || (x_in > HALF) || (y_in > HALF) || (y_in < -HALF);
  end

  cordic_microrot #(
    .WORD_LENGTH (WORD_LENGTH),
    .ITER_W      (ITER_W)
  ) u_microrot (
    .x     (vec_q.x),
    .y     (vec_q.y),
    .z     (vec_q.z),
    .alpha (alpha),
    .i     (iter_q),
    .mode  (mode_q),
    .x_nxt (vec_nxt.x),
    .y_nxt (vec_nxt.y),
    .z_nxt (vec_nxt.z)
  );

  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    mode_d  = mode_q;
    err_d   = err_q;
    vec_d   = vec_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_BUSY;
          iter_d  = '0;
          mode_d  = mode_e'(mode);
          if (mode_e'(mode) == MODE_VEC) begin
            err_d = vec_err;
            vec_d = '{x: x_in, y: y_in, z: '0};
          end else begin
            err_d = rot_err;
            vec_d = '{x: INV_GAIN, y: '0, z: z_in};
          end
        end
      end
      ST_BUSY: begin
        vec_d = vec_nxt;
        if (iter_q == LAST_ITER) begin
          state_d = ST_DONE;
          iter_d  = '0;
          // range errors still take the full latency but report a zero result
          res_d   = err_q ? '0 : vec_nxt;
        end else begin
          iter_d = iter_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
      mode_q  <= MODE_ROT;
      err_q   <= 1'b0;
      vec_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign x_out     = res_q.x;
  assign y_out     = res_q.y;
  assign z_out     = res_q.z;
  assign err       = err_q && (state_q == ST_DONE);

endmodule
